// File: rtl/mem_port_master_pkg.sv
// mem_port_master_pkg: shared FSM states, port-select encoding and RAM geometry for the memory port master.
package mem_port_master_pkg;
  localparam int RAM_AW = 9;
  localparam int RAM_WORDS = 512;
  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RESP} state_t;
  typedef enum logic {SEL_IF, SEL_D} sel_t;
  function automatic logic addr_ok(input logic [31:0] a, input int aw);
    return (a >> aw) == 32'd0;
  endfunction
endpackage

// File: rtl/mem_port_master_if.sv
// mem_port_master_if: CPU request/response ports plus RAM strobes, seen as master by the port and slave by the CPU/RAM side.
interface mem_port_master_if #(parameter int AW = 9, parameter int DW = 32);
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [31:0]   d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          addr_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_rdata;
  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, addr_err, mem_addr, mem_wdata, mem_read, mem_write
  );
  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, addr_err, mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/mem_req_arb.sv
// mem_req_arb: combinational fixed-priority arbiter, data port beats fetch.
module mem_req_arb
  import mem_port_master_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [31:0]   d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          gnt,
  output sel_t          sel,
  output logic [31:0]   addr,
  output logic          we,
  output logic [DW-1:0] wdata
);
  always_comb begin
    gnt   = if_req | d_req;
    sel   = d_req ? SEL_D : SEL_IF;
    addr  = d_req ? d_addr : if_addr;
    we    = d_req & d_we;
    wdata = d_wdata;
  end
endmodule

// File: rtl/mem_port_master.sv
// mem_port_master: arbitrates fetch/data requests onto a registered-output synchronous RAM port.
module mem_port_master
  import mem_port_master_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int DW = 32
) (
  input logic clk,
  input logic clr_n,
  mem_port_master_if.master bus
);
  state_t        state;
  sel_t          sel;
  logic          err;
  logic          we;
  logic          gnt;
  sel_t          a_sel;
  logic [31:0]   a_addr;
  logic          a_we;
  logic [DW-1:0] a_wdata;
  logic          ok;
  mem_req_arb #(.DW(DW)) u_arb (
    .if_req (bus.if_req),
    .if_addr(bus.if_addr),
    .d_req  (bus.d_req),
    .d_we   (bus.d_we),
    .d_addr (bus.d_addr),
    .d_wdata(bus.d_wdata),
    .gnt    (gnt),
    .sel    (a_sel),
    .addr   (a_addr),
    .we     (a_we),
    .wdata  (a_wdata)
  );
  assign ok = addr_ok(a_addr, AW);
  // Async clear also kills an in-flight mem_write so no partial store survives reset.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state         <= IDLE;
      sel           <= SEL_IF;
      err           <= 1'b0;
      we            <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.if_ack    <= 1'b0;
      bus.d_ack     <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_rdata   <= '0;
      bus.addr_err  <= 1'b0;
    end else begin
      bus.if_ack   <= 1'b0;
      bus.d_ack    <= 1'b0;
      bus.addr_err <= 1'b0;
      case (state)
        IDLE: if (gnt) begin
          sel   <= a_sel;
          we    <= a_we;
          err   <= !ok;
          state <= ok ? ISSUE : RESP;
          if (ok) begin
            bus.mem_addr  <= a_addr[AW-1:0];
            bus.mem_read  <= !a_we;
            bus.mem_write <= a_we;
            if (a_we) bus.mem_wdata <= a_wdata;
          end
        end
        ISSUE: begin
          bus.mem_read  <= 1'b0;
          bus.mem_write <= 1'b0;
          state         <= we ? RESP : RD_WAIT;
        end
        RD_WAIT: begin
          if (sel == SEL_D) bus.d_rdata <= bus.mem_rdata;
          else bus.if_rdata <= bus.mem_rdata;
          state <= RESP;
        end
        RESP: begin
          bus.d_ack    <= sel == SEL_D;
          bus.if_ack   <= sel == SEL_IF;
          bus.addr_err <= err;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
